rv32i_decoder: RTL and testbench
================================

// Module: rv32i_decoder
// PURPOSE
//  Combinational RV32I instruction decoder for pipeline stage 0 -> 1; outputs are captured into pipeReg1
//    together with the register-file operands.
//  Splits the fetched word into fields, a sign-extended immediate, a one-hot format code and a 64-bit one-hot instruction ID.
//  Clocked logic is limited to illegal-instruction bookkeeping.
// PARAMETERS
//  N_param  32  instruction width; only 32 is supported.
// PORTS
//  i_clk                 in   1   clock, rising edge
//  i_reset_n             in   1   asynchronous, active-low reset
//  i_en                  in   1   decode enable; 0 = bubble
//  instruction           in   32  instruction word
//  rd_o                  out  5   destination register
//  rs1_o                 out  5   source register 1
//  rs2_o                 out  5   source register 2
//  fun3_o                out  3   instruction[14:12]
//  fun7_o                out  7   instruction[31:25]
//  imm_o                 out  32  decoded immediate
//  INST_typ_o            out  7   one-hot format: [0]R [1]I [2]S [3]B [4]U [5]J [6]=0
//  opcode_o              out  7   instruction[6:0]
//  Single_Instruction_o  out  64  one-hot instruction ID; all-zero = no valid instruction
//  illegal_o             out  1   sticky illegal-instruction flag (registered)
// BEHAVIOUR
//  Field outputs are combinational, 0-cycle latency. illegal_o is the only registered output; reset value 0.
//  ID bits:
//    0 LUI, 1 AUIPC, 2 JAL, 3 JALR
//    4-9 BEQ BNE BLT BGE BLTU BGEU
//    10-14 LB LH LW LBU LHU, 15-17 SB SH SW
//    18-26 ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
//    27-36 ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
//    37 FENCE, 38 ECALL, 39 EBREAK
//    40-63 always 0
//  Matching:
//    full opcode/fun3 match
//    fun7 checked on R-type and on SLLI/SRLI/SRAI; 0x20 only for SUB/SRA/SRAI
//    ECALL = 0x00000073 exactly, EBREAK = 0x00100073 exactly
//  Immediates:
//    I = sext[31:20]
//    S = sext{[31:25],[11:7]}
//    B = sext{[31],[7],[30:25],[11:8],0}
//    U = {[31:12],12'b0}
//    J = sext{[31],[19:12],[20],[30:21],0}
//    shifts = {27'b0,[24:20]}
//    R and illegal = 0
//  Register fields (all zero when illegal):
//    rd_o = 0 for S/B
//    rs1_o = 0 for U/J
//    rs2_o = 0 unless R/S/B
//  Illegal or all-zero word: INST_typ_o = 0, Single_Instruction_o = 0, imm_o = 0; opcode_o/fun3_o/fun7_o are still raw.
//  i_en = 0: every combinational output forced to 0.
//  illegal_o is set at posedge i_clk when i_en = 1, instruction != 0 and the ID is all-zero.
//  illegal_o clears only on reset; reset asserted mid-cycle clears it immediately.
//  The all-zero word is a pipeline bubble (post-reset pipeReg0): it never sets illegal_o.
// CONFIGURATION
//  DECODE_ILLEGAL_CNT_EN defined:
//    adds output illegal_cnt_o [15:0]
//    increments on every cycle that would set illegal_o, whether or not the flag is already set
//    saturates at 0xFFFF; reset value 0
//  Undefined: the port and counter do not exist; all other behaviour is identical.
// STRUCTURE
//  Package rv32i_pkg:
//    opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BR 1100011,
//      LD 0000011, ST 0100011, OPI 0010011, OP 0110011, FENCE 0001111, SYS 1110011)
//    ID bit-index localparams, INST_typ bit indices
//  Sub-module rv32i_imm_gen: instruction + format -> imm_o.
// TESTING
//  0x00500093 (addi x1,x0,5) -> rd=1 rs1=0 rs2=0 imm=5 typ=0x02 ID bit18 only.
//  0x40208133 (sub x2,x1,x2) -> typ=0x01 ID bit28 imm=0; 0x00208133 -> bit27.
//  0xFE112E23 (sw x1,-4(x2)) -> imm=0xFFFFFFFC rd=0 typ=0x04 ID bit17.
//  0xFE0008E3 (beq x0,x0,-16) -> imm=0xFFFFFFF0 typ=0x08 ID bit4.
//    0x123450B7 (lui) -> imm=0x12345000 rs1=0.
//  0xFFFFFFFF with i_en=1 -> ID=0 and illegal_o=1 next edge; 0x00000000 -> illegal_o unchanged.
//    i_reset_n low -> illegal_o=0 immediately.
//  i_en=0 with a valid word -> all outputs 0, illegal_o held.
//    With DECODE_ILLEGAL_CNT_EN: 3 illegal cycles -> illegal_cnt_o=3.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I decoder: opcodes, one-hot instruction ID
// bit positions and format-code bit positions.
package rv32i_pkg;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;
  localparam logic [6:0] OPC_SYS   = 7'b1110011;

  // fun7 values that are legal on R-type and immediate shifts
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Exact encodings of the two system instructions
  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  // One-hot instruction ID bit positions
  localparam int ID_LUI = 0, ID_AUIPC = 1, ID_JAL = 2, ID_JALR = 3;
  localparam int ID_BEQ = 4, ID_BNE = 5, ID_BLT = 6, ID_BGE = 7, ID_BLTU = 8, ID_BGEU = 9;
  localparam int ID_LB = 10, ID_LH = 11, ID_LW = 12, ID_LBU = 13, ID_LHU = 14;
  localparam int ID_SB = 15, ID_SH = 16, ID_SW = 17;
  localparam int ID_ADDI = 18, ID_SLTI = 19, ID_SLTIU = 20, ID_XORI = 21, ID_ORI = 22;
  localparam int ID_ANDI = 23, ID_SLLI = 24, ID_SRLI = 25, ID_SRAI = 26;
  localparam int ID_ADD = 27, ID_SUB = 28, ID_SLL = 29, ID_SLT = 30, ID_SLTU = 31;
  localparam int ID_XOR = 32, ID_SRL = 33, ID_SRA = 34, ID_OR = 35, ID_AND = 36;
  localparam int ID_FENCE = 37, ID_ECALL = 38, ID_EBREAK = 39;

  // Format code bit positions (bit 6 is never set)
  localparam int TYP_R = 0, TYP_I = 1, TYP_S = 2, TYP_B = 3, TYP_U = 4, TYP_J = 5;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Immediate generator: builds the sign-extended immediate from the upper
// instruction bits and the one-hot format (R-type and "no format" give 0).
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] i_instr,
  input  logic [5:1]  i_typ,    // one-hot format bits I..J
  input  logic        i_shift,  // SLLI/SRLI/SRAI: immediate is the shamt
  output logic [31:0] o_imm
);

  // Select the immediate layout for the decoded format
  always_comb begin
    o_imm = '0;
    if (i_typ[TYP_I]) begin
      if (i_shift) o_imm = {27'b0, i_instr[24:20]};
      else         o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
    end else if (i_typ[TYP_S]) begin
      o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    end else if (i_typ[TYP_B]) begin
      o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    end else if (i_typ[TYP_U]) begin
      o_imm = {i_instr[31:12], 12'b0};
    end else if (i_typ[TYP_J]) begin
      o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    end
  end

endmodule

// File: rtl/rv32i_decoder.sv
// RV32I decoder for pipeline stage 0 -> 1. Field outputs are combinational;
// the only state is the sticky illegal-instruction flag.
// Optional feature macro: DECODE_ILLEGAL_CNT_EN adds illegal_cnt_o, a
// saturating count of cycles that would set the illegal flag.
module rv32i_decoder
  import rv32i_pkg::*;
#(
  parameter int N_param = 32
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_en,
  input  logic [N_param-1:0] instruction,
  output logic [4:0]         rd_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [2:0]         fun3_o,
  output logic [6:0]         fun7_o,
  output logic [31:0]        imm_o,
  output logic [6:0]         INST_typ_o,
  output logic [6:0]         opcode_o,
  output logic [63:0]        Single_Instruction_o,
`ifdef DECODE_ILLEGAL_CNT_EN
  output logic [15:0]        illegal_cnt_o,
`endif
  output logic               illegal_o
);

  logic [6:0]  w_opcode, w_fun7, w_fmt, w_typ;
  logic [2:0]  w_fun3;
  logic [63:0] w_id;
  logic [31:0] w_imm;
  logic        w_shift, w_legal, w_set_illegal;
  logic        r_illegal;

  assign w_opcode = instruction[6:0];
  assign w_fun3   = instruction[14:12];
  assign w_fun7   = instruction[31:25];

  // Full opcode/fun3(/fun7) match producing the one-hot ID and its format
  always_comb begin
    w_id    = '0;
    w_fmt   = '0;
    w_shift = 1'b0;
    case (w_opcode)
      OPC_LUI:   begin w_id[ID_LUI] = 1'b1;   w_fmt[TYP_U] = 1'b1; end
      OPC_AUIPC: begin w_id[ID_AUIPC] = 1'b1; w_fmt[TYP_U] = 1'b1; end
      OPC_JAL:   begin w_id[ID_JAL] = 1'b1;   w_fmt[TYP_J] = 1'b1; end
      OPC_JALR:  begin w_id[ID_JALR] = (w_fun3 == 3'b000); w_fmt[TYP_I] = 1'b1; end
      OPC_BR: begin
        w_fmt[TYP_B] = 1'b1;
        case (w_fun3)
          3'b000:  w_id[ID_BEQ]  = 1'b1;
          3'b001:  w_id[ID_BNE]  = 1'b1;
          3'b100:  w_id[ID_BLT]  = 1'b1;
          3'b101:  w_id[ID_BGE]  = 1'b1;
          3'b110:  w_id[ID_BLTU] = 1'b1;
          3'b111:  w_id[ID_BGEU] = 1'b1;
          default: w_id = '0;
        endcase
      end
      OPC_LD: begin
        w_fmt[TYP_I] = 1'b1;
        case (w_fun3)
          3'b000:  w_id[ID_LB]  = 1'b1;
          3'b001:  w_id[ID_LH]  = 1'b1;
          3'b010:  w_id[ID_LW]  = 1'b1;
          3'b100:  w_id[ID_LBU] = 1'b1;
          3'b101:  w_id[ID_LHU] = 1'b1;
          default: w_id = '0;
        endcase
      end
      OPC_ST: begin
        w_fmt[TYP_S] = 1'b1;
        case (w_fun3)
          3'b000:  w_id[ID_SB] = 1'b1;
          3'b001:  w_id[ID_SH] = 1'b1;
          3'b010:  w_id[ID_SW] = 1'b1;
          default: w_id = '0;
        endcase
      end
      OPC_OPI: begin
        w_fmt[TYP_I] = 1'b1;
        w_shift      = (w_fun3 == 3'b001) || (w_fun3 == 3'b101);
        case (w_fun3)
          3'b000:  w_id[ID_ADDI]  = 1'b1;
          3'b010:  w_id[ID_SLTI]  = 1'b1;
          3'b011:  w_id[ID_SLTIU] = 1'b1;
          3'b100:  w_id[ID_XORI]  = 1'b1;
          3'b110:  w_id[ID_ORI]   = 1'b1;
          3'b111:  w_id[ID_ANDI]  = 1'b1;
          3'b001:  w_id[ID_SLLI]  = (w_fun7 == F7_BASE);
          3'b101: begin
            w_id[ID_SRLI] = (w_fun7 == F7_BASE);
            w_id[ID_SRAI] = (w_fun7 == F7_ALT);
          end
          default: w_id = '0;
        endcase
      end
      OPC_OP: begin
        w_fmt[TYP_R] = 1'b1;
        if (w_fun7 == F7_BASE) begin
          case (w_fun3)
            3'b000:  w_id[ID_ADD]  = 1'b1;
            3'b001:  w_id[ID_SLL]  = 1'b1;
            3'b010:  w_id[ID_SLT]  = 1'b1;
            3'b011:  w_id[ID_SLTU] = 1'b1;
            3'b100:  w_id[ID_XOR]  = 1'b1;
            3'b101:  w_id[ID_SRL]  = 1'b1;
            3'b110:  w_id[ID_OR]   = 1'b1;
            default: w_id[ID_AND]  = 1'b1;
          endcase
        end else if (w_fun7 == F7_ALT) begin
          w_id[ID_SUB] = (w_fun3 == 3'b000);
          w_id[ID_SRA] = (w_fun3 == 3'b101);
        end
      end
      OPC_FENCE: begin w_id[ID_FENCE] = (w_fun3 == 3'b000); w_fmt[TYP_I] = 1'b1; end
      OPC_SYS: begin
        w_fmt[TYP_I]    = 1'b1;
        w_id[ID_ECALL]  = (instruction == ECALL_WORD);
        w_id[ID_EBREAK] = (instruction == EBREAK_WORD);
      end
      default: w_id = '0;
    endcase
  end

  // Format only reported for a recognised instruction
  assign w_legal = |w_id;
  assign w_typ   = w_legal ? w_fmt : 7'b0;

  rv32i_imm_gen u_imm_gen (
    .i_instr (instruction[31:7]),
    .i_typ   (w_typ[5:1]),
    .i_shift (w_shift),
    .o_imm   (w_imm)
  );

  // Output gating: i_en = 0 is a bubble, illegal words zero the register fields
  always_comb begin
    opcode_o             = i_en ? w_opcode : 7'b0;
    fun3_o               = i_en ? w_fun3 : 3'b0;
    fun7_o               = i_en ? w_fun7 : 7'b0;
    imm_o                = i_en ? w_imm : 32'b0;
    INST_typ_o           = i_en ? w_typ : 7'b0;
    Single_Instruction_o = i_en ? w_id : 64'b0;
    rd_o  = (i_en && w_legal && !(w_typ[TYP_S] || w_typ[TYP_B])) ? instruction[11:7] : 5'b0;
    rs1_o = (i_en && w_legal && !(w_typ[TYP_U] || w_typ[TYP_J])) ? instruction[19:15] : 5'b0;
    rs2_o = (i_en && (w_typ[TYP_R] || w_typ[TYP_S] || w_typ[TYP_B])) ? instruction[24:20] : 5'b0;
  end

  // The all-zero word is a bubble and never counts as illegal
  assign w_set_illegal = i_en && (instruction != '0) && !w_legal;

  // Sticky illegal flag, cleared only by reset
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)         r_illegal <= 1'b0;
    else if (w_set_illegal) r_illegal <= 1'b1;
  end

  assign illegal_o = r_illegal;

`ifdef DECODE_ILLEGAL_CNT_EN
  logic [15:0] r_illegal_cnt;

  // Saturating count of every cycle that would set the illegal flag
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_illegal_cnt <= 16'h0;
    else if (w_set_illegal && (r_illegal_cnt != 16'hFFFF))
      r_illegal_cnt <= r_illegal_cnt + 16'h1;
  end

  assign illegal_cnt_o = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_rv32i_decoder.sv
// Directed-vector bench for rv32i_decoder with hand-computed expectations.
module tb_rv32i_decoder;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_en = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  fun3_o;
  logic [6:0]  fun7_o, INST_typ_o, opcode_o;
  logic [31:0] imm_o;
  logic [63:0] Single_Instruction_o;
  logic        illegal_o;
`ifdef DECODE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  rv32i_decoder #(.N_param(32)) dut (
    .i_clk                (i_clk),
    .i_reset_n            (i_reset_n),
    .i_en                 (i_en),
    .instruction          (instruction),
    .rd_o                 (rd_o),
    .rs1_o                (rs1_o),
    .rs2_o                (rs2_o),
    .fun3_o               (fun3_o),
    .fun7_o               (fun7_o),
    .imm_o                (imm_o),
    .INST_typ_o           (INST_typ_o),
    .opcode_o             (opcode_o),
    .Single_Instruction_o (Single_Instruction_o),
`ifdef DECODE_ILLEGAL_CNT_EN
    .illegal_cnt_o        (illegal_cnt_o),
`endif
    .illegal_o            (illegal_o)
  );

  always #5 i_clk = ~i_clk;

  // Single comparison point: counts every check, reports mismatches
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive a word away from the rising edge and let the logic settle
  task automatic apply(input logic [31:0] w, input logic en);
    @(negedge i_clk);
    instruction = w;
    i_en        = en;
    #1;
    $display("vec instr=0x%08h en=%0d id=0x%016h typ=0x%02h imm=0x%08h ill=%0d",
             w, en, Single_Instruction_o, INST_typ_o, imm_o, illegal_o);
  endtask

  // Common decoded-field checks for one vector
  task automatic chk_dec(input string nm, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm,
                         input logic [6:0] typ, input logic [63:0] id);
    chk({nm, ".rd"},  64'(rd_o),  64'(rd));
    chk({nm, ".rs1"}, 64'(rs1_o), 64'(rs1));
    chk({nm, ".rs2"}, 64'(rs2_o), 64'(rs2));
    chk({nm, ".imm"}, 64'(imm_o), 64'(imm));
    chk({nm, ".typ"}, 64'(INST_typ_o), 64'(typ));
    chk({nm, ".id"},  Single_Instruction_o, id);
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset.illegal", 64'(illegal_o), 64'h0);
`ifdef DECODE_ILLEGAL_CNT_EN
    chk("reset.cnt", 64'(illegal_cnt_o), 64'h0);
`endif
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Legal instructions of each format
    apply(32'h0050_0093, 1'b1);   // addi x1,x0,5
    chk_dec("addi", 5'd1, 5'd0, 5'd0, 32'h5, 7'h02, 64'h1 << 18);
    chk("addi.opcode", 64'(opcode_o), 64'h13);

    apply(32'h4020_8133, 1'b1);   // sub x2,x1,x2
    chk_dec("sub", 5'd2, 5'd1, 5'd2, 32'h0, 7'h01, 64'h1 << 28);
    chk("sub.fun7", 64'(fun7_o), 64'h20);

    apply(32'h0020_8133, 1'b1);   // add x2,x1,x2
    chk_dec("add", 5'd2, 5'd1, 5'd2, 32'h0, 7'h01, 64'h1 << 27);

    apply(32'hFE11_2E23, 1'b1);   // sw x1,-4(x2)
    chk_dec("sw", 5'd0, 5'd2, 5'd1, 32'hFFFF_FFFC, 7'h04, 64'h1 << 17);
    chk("sw.fun3", 64'(fun3_o), 64'h2);

    apply(32'hFE00_08E3, 1'b1);   // beq x0,x0,-16
    chk_dec("beq", 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF0, 7'h08, 64'h1 << 4);

    apply(32'h1234_50B7, 1'b1);   // lui x1,0x12345
    chk_dec("lui", 5'd1, 5'd0, 5'd0, 32'h1234_5000, 7'h10, 64'h1 << 0);

    apply(32'h0080_00EF, 1'b1);   // jal x1,8
    chk_dec("jal", 5'd1, 5'd0, 5'd0, 32'h8, 7'h20, 64'h1 << 2);

    apply(32'h4031_5093, 1'b1);   // srai x1,x2,3
    chk_dec("srai", 5'd1, 5'd2, 5'd0, 32'h3, 7'h02, 64'h1 << 26);

    apply(32'h0000_0073, 1'b1);   // ecall
    chk_dec("ecall", 5'd0, 5'd0, 5'd0, 32'h0, 7'h02, 64'h1 << 38);

    apply(32'h0010_0073, 1'b1);   // ebreak
    chk_dec("ebreak", 5'd0, 5'd0, 5'd0, 32'h1, 7'h02, 64'h1 << 39);

    // Bubble word never sets the flag
    apply(32'h0000_0000, 1'b1);
    chk("bubble.id", Single_Instruction_o, 64'h0);
    @(posedge i_clk); #1;
    chk("bubble.illegal", 64'(illegal_o), 64'h0);

    // Disabled decode of an illegal word: no flag
    apply(32'hFFFF_FFFF, 1'b0);
    @(posedge i_clk); #1;
    chk("en0.illegal", 64'(illegal_o), 64'h0);

    // Illegal word with wrong fun7 on a shift: fields zero, raw fields kept
    apply(32'h6031_5093, 1'b1);
    chk_dec("badsrai", 5'd0, 5'd0, 5'd0, 32'h0, 7'h00, 64'h0);
    chk("badsrai.opcode", 64'(opcode_o), 64'h13);
    chk("badsrai.fun7", 64'(fun7_o), 64'h30);
    chk("badsrai.pre", 64'(illegal_o), 64'h0);
    @(posedge i_clk); #1;
    chk("badsrai.illegal", 64'(illegal_o), 64'h1);

    // ecall with nonzero rd is not ECALL
    apply(32'h0000_00F3, 1'b1);
    chk("ecallrd.id", Single_Instruction_o, 64'h0);

    // i_en = 0 with a valid word: outputs forced to zero, flag held
    apply(32'h4020_8133, 1'b0);
    chk_dec("en0", 5'd0, 5'd0, 5'd0, 32'h0, 7'h00, 64'h0);
    chk("en0.opcode", 64'(opcode_o), 64'h0);
    chk("en0.fun7", 64'(fun7_o), 64'h0);
    @(posedge i_clk); #1;
    chk("en0.held", 64'(illegal_o), 64'h1);

    // Asynchronous reset mid-cycle clears the flag immediately
    @(negedge i_clk); #2;
    i_reset_n = 1'b0;
    #1;
    chk("async.illegal", 64'(illegal_o), 64'h0);
`ifdef DECODE_ILLEGAL_CNT_EN
    chk("async.cnt", 64'(illegal_cnt_o), 64'h0);
`endif
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // 0xFFFFFFFF held for three rising edges
    apply(32'hFFFF_FFFF, 1'b1);
    chk("ones.id", Single_Instruction_o, 64'h0);
    chk("ones.typ", 64'(INST_typ_o), 64'h0);
    @(posedge i_clk); #1;
    chk("ones.illegal", 64'(illegal_o), 64'h1);
    @(posedge i_clk);
    @(posedge i_clk); #1;
    i_en = 1'b0;
`ifdef DECODE_ILLEGAL_CNT_EN
    chk("ones.cnt", 64'(illegal_cnt_o), 64'h3);
`endif
    chk("ones.sticky", 64'(illegal_o), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
